demux_1to2_buf: RTL and testbench
=================================

Name: demux_1to2_buf

Overview:
- Inverse of the datapath 2-to-1 select. Routes one incoming 8-bit word stream to one of two output channels, chosen per word by `Signal`.
- Each output channel has its own small FIFO, so a stalled consumer on one channel does not block words bound for the other channel.
- Sits between a producer (for example, ALU/result staging) and two independent consumers (for example, register write-back and memory write-data staging).

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 2, entries per channel FIFO. Power of two, minimum 2.
- ADDR_W, 1, pointer width; must equal log2(DEPTH).

Ports:
- clock  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high reset.
- In  input  WIDTH  incoming data word.
- Signal  input  1  destination select: 0 → channel 1, 1 → channel 2.
- in_valid  input  1  producer has a word on In/Signal.
- in_ready  output  1  word on In will be accepted this cycle.
- out1  output  WIDTH  channel 1 head word.
- out1_valid  output  1  channel 1 FIFO non-empty.
- out1_ready  input  1  channel 1 consumer takes the head word.
- out2  output  WIDTH  channel 2 head word.
- out2_valid  output  1  channel 2 FIFO non-empty.
- out2_ready  input  1  channel 2 consumer takes the head word.

Behaviour:
- Reset (synchronous, reset=1 at a rising edge):
  - Both FIFOs emptied: read/write pointers and occupancy counts set to 0.
  - Outputs after that edge: out1_valid=0, out2_valid=0, out1=0, out2=0.
  - in_ready then reflects an empty FIFO (1).
  - Reset overrides any push or pop in the same cycle; any word presented during reset is dropped.
  - Reset mid-stream discards all buffered words.
- Per-channel FIFO state: mem[DEPTH], rd_ptr, wr_ptr (ADDR_W bits each, wrap modulo DEPTH), count (ADDR_W+1 bits, range 0..DEPTH).
  - full = (count == DEPTH).
  - empty = (count == 0).
- in_ready = !full of the channel selected by the current Signal. Combinational from Signal and registered count.
  - No same-cycle pass-through: a full channel deasserts in_ready even if its consumer pops that cycle.
- Push: in_valid & in_ready at an edge.
  - In is written to mem[wr_ptr] of the selected channel.
  - That channel's wr_ptr increments; its count increments unless a pop happens on the same channel in the same cycle.
- Pop on channel k: outk_valid & outk_ready at an edge.
  - rd_ptr increments; count decrements unless a push happens on the same channel in the same cycle.
- Simultaneous push and pop on one channel: count unchanged, both pointers advance.
- Pop on one channel and push on the other in the same cycle are independent.
- outk_valid = !empty.
- outk = mem[rd_ptr] when non-empty, else 0. Combinational read of registered storage.
- Latency: a word pushed at edge N is visible on outk with outk_valid=1 after edge N (one cycle). No bypass path from In to outk.
- Ordering: FIFO order is preserved within a channel. No ordering relation between channels.
- outk_ready while outk_valid=0: ignored, no state change.
- in_valid=0: Signal and In are ignored.
- Pointer wrap-around at DEPTH-1 → 0 must not corrupt data or count.

Optional Feature:
- Macro: DEMUX_STATS_EN.
- With the macro defined:
  - Adds output ports cnt1 and cnt2, each 8 bits wide.
  - cntk increments by 1 on every accepted push to channel k, wrapping 255 → 0.
  - Both counters clear on reset.
  - Adds output `drop` (1 bit), registered: 1 for one cycle after any edge where in_valid=1 and in_ready=0.
- Without the macro: no extra ports, logic, or registers; behaviour is otherwise identical.

Test Plan:
- Reset, then idle: out1_valid=0, out2_valid=0, out1=0, out2=0, in_ready=1 for both Signal values.
- Push In=8'hA5, Signal=0, single cycle: next cycle out1=8'hA5, out1_valid=1, out2_valid=0. Pulse out1_ready → out1_valid=0, out1=0.
- Fill channel 2 (DEPTH=2) with 8'h11 then 8'h22, out2_ready=0:
  - Third push with Signal=1: in_ready=0, word not stored.
  - Same cycle, push with Signal=0: in_ready=1, word accepted into channel 1.
  - Drain channel 2 → 8'h11 then 8'h22.
- Channel 1 at count=1 with continuous push and pop for 5 cycles, words 8'h01..8'h05: count stays 1, pointers wrap, words emerge in order 8'h01..8'h05.
- Assert reset while both channels hold data: after the edge both valids=0; the next push of 8'h3C with Signal=1 appears on out2 one cycle later.
- With DEMUX_STATS_EN defined:
  - 300 pushes to channel 1 → cnt1=44 (300 mod 256); cnt2 unchanged.
  - in_valid=1 with the selected channel full → drop=1 on the following cycle.

Source files
------------

// File: rtl/demux_1to2_buf.sv
// Routes one word stream into two independently buffered output channels.
// Optional statistics ports (push counters, drop flag) are enabled by DEMUX_STATS_EN.
module demux_1to2_buf #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 2,
   parameter int ADDR_W = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] In,
   input  logic             Signal,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out1,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [WIDTH-1:0] out2,
   output logic             out2_valid,
   input  logic             out2_ready
`ifdef DEMUX_STATS_EN
   ,
   output logic [7:0]       cnt1,
   output logic [7:0]       cnt2,
   output logic             drop
`endif
);

   localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   logic [WIDTH-1:0]  r_mem1 [DEPTH];
   logic [WIDTH-1:0]  r_mem2 [DEPTH];
   logic [ADDR_W-1:0] r_rd1;
   logic [ADDR_W-1:0] r_wr1;
   logic [ADDR_W-1:0] r_rd2;
   logic [ADDR_W-1:0] r_wr2;
   logic [ADDR_W:0]   r_cnt1;
   logic [ADDR_W:0]   r_cnt2;

   logic w_full1;
   logic w_full2;
   logic w_empty1;
   logic w_empty2;
   logic w_push1;
   logic w_push2;
   logic w_pop1;
   logic w_pop2;

   assign w_full1  = (r_cnt1 == FULL_CNT);
   assign w_full2  = (r_cnt2 == FULL_CNT);
   assign w_empty1 = (r_cnt1 == '0);
   assign w_empty2 = (r_cnt2 == '0);

   // Readiness looks only at registered occupancy, so a full channel stalls even if it pops now.
   assign in_ready = Signal ? !w_full2 : !w_full1;

   assign w_push1 = in_valid & in_ready & !Signal;
   assign w_push2 = in_valid & in_ready & Signal;
   assign w_pop1  = !w_empty1 & out1_ready;
   assign w_pop2  = !w_empty2 & out2_ready;

   assign out1_valid = !w_empty1;
   assign out2_valid = !w_empty2;
   assign out1       = w_empty1 ? '0 : r_mem1[r_rd1];
   assign out2       = w_empty2 ? '0 : r_mem2[r_rd2];

   // Storage is left unreset; the zeroed counts make stale contents unreachable.
   always_ff @(posedge clock) begin
      if (w_push1 && !reset) begin
         r_mem1[r_wr1] <= In;
      end
      if (w_push2 && !reset) begin
         r_mem2[r_wr2] <= In;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_rd1  <= '0;
         r_wr1  <= '0;
         r_cnt1 <= '0;
         r_rd2  <= '0;
         r_wr2  <= '0;
         r_cnt2 <= '0;
      end else begin
         if (w_push1) begin
            r_wr1 <= r_wr1 + PTR_ONE;
         end
         if (w_pop1) begin
            r_rd1 <= r_rd1 + PTR_ONE;
         end
         case ({w_push1, w_pop1})
            2'b10:   r_cnt1 <= r_cnt1 + CNT_ONE;
            2'b01:   r_cnt1 <= r_cnt1 - CNT_ONE;
            default: r_cnt1 <= r_cnt1;
         endcase

         if (w_push2) begin
            r_wr2 <= r_wr2 + PTR_ONE;
         end
         if (w_pop2) begin
            r_rd2 <= r_rd2 + PTR_ONE;
         end
         case ({w_push2, w_pop2})
            2'b10:   r_cnt2 <= r_cnt2 + CNT_ONE;
            2'b01:   r_cnt2 <= r_cnt2 - CNT_ONE;
            default: r_cnt2 <= r_cnt2;
         endcase
      end
   end

`ifdef DEMUX_STATS_EN
   logic [7:0] r_pushCnt1;
   logic [7:0] r_pushCnt2;
   logic       r_drop;

   // Counters wrap naturally at 8 bits; drop flags a refused word for one cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_pushCnt1 <= '0;
         r_pushCnt2 <= '0;
         r_drop     <= 1'b0;
      end else begin
         if (w_push1) begin
            r_pushCnt1 <= r_pushCnt1 + 8'd1;
         end
         if (w_push2) begin
            r_pushCnt2 <= r_pushCnt2 + 8'd1;
         end
         r_drop <= in_valid & !in_ready;
      end
   end

   assign cnt1 = r_pushCnt1;
   assign cnt2 = r_pushCnt2;
   assign drop = r_drop;
`endif

endmodule

// File: tb/tb_demux_1to2_buf.sv
// Scoreboard bench for demux_1to2_buf: driver fills per-channel expectation queues, monitor pops them.
// Statistics ports are checked when DEMUX_STATS_EN is defined.
module tb_demux_1to2_buf;

   localparam int W = 8;
   localparam int D = 2;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] In = '0;
   logic         Signal = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] out1;
   logic         out1_valid;
   logic         out1_ready = 1'b0;
   logic [W-1:0] out2;
   logic         out2_valid;
   logic         out2_ready = 1'b0;
`ifdef DEMUX_STATS_EN
   logic [7:0]   cnt1;
   logic [7:0]   cnt2;
   logic         drop;
   int           expCnt1 = 0;
   int           expCnt2 = 0;
   logic         pendDrop = 1'b0;
`endif

   int total = 0;
   int bad = 0;

   logic [W-1:0] q1[$];
   logic [W-1:0] q2[$];
   int           occ1 = 0;
   int           occ2 = 0;
   logic         pendReset = 1'b1;
   logic         pendPush = 1'b0;
   logic         pendSel = 1'b0;
   logic [W-1:0] pendData = '0;
   logic         pendPop1 = 1'b0;
   logic         pendPop2 = 1'b0;

   demux_1to2_buf #(.WIDTH(W), .DEPTH(D), .ADDR_W(1)) dut (
      .clock(clock),
      .reset(reset),
      .In(In),
      .Signal(Signal),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .out1(out1),
      .out1_valid(out1_valid),
      .out1_ready(out1_ready),
      .out2(out2),
      .out2_valid(out2_valid),
      .out2_ready(out2_ready)
`ifdef DEMUX_STATS_EN
      ,
      .cnt1(cnt1),
      .cnt2(cnt2),
      .drop(drop)
`endif
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // One cycle: commit last cycle's effect to the model, drive new inputs, check readiness.
   task automatic applyStimulus(input logic rst, input logic v, input logic sel,
                                input logic [W-1:0] d, input logic r1, input logic r2);
      logic expReady;
      @(posedge clock);
      #1;
      if (pendReset) begin
         q1.delete();
         q2.delete();
         occ1 = 0;
         occ2 = 0;
`ifdef DEMUX_STATS_EN
         expCnt1 = 0;
         expCnt2 = 0;
         pendDrop = 1'b0;
`endif
      end else begin
         if (pendPop1) occ1--;
         if (pendPop2) occ2--;
         if (pendPush) begin
            if (pendSel) begin
               q2.push_back(pendData);
               occ2++;
`ifdef DEMUX_STATS_EN
               expCnt2 = (expCnt2 + 1) % 256;
`endif
            end else begin
               q1.push_back(pendData);
               occ1++;
`ifdef DEMUX_STATS_EN
               expCnt1 = (expCnt1 + 1) % 256;
`endif
            end
         end
      end
`ifdef DEMUX_STATS_EN
      checkOutput("cnt1", 32'(cnt1), 32'(expCnt1));
      checkOutput("cnt2", 32'(cnt2), 32'(expCnt2));
      checkOutput("drop", 32'(drop), 32'(pendDrop));
`endif
      reset      = rst;
      in_valid   = v;
      Signal     = sel;
      In         = d;
      out1_ready = r1;
      out2_ready = r2;
      expReady   = sel ? (occ2 < D) : (occ1 < D);
      #1;
      checkOutput("in_ready", 32'(in_ready), 32'(expReady));
      pendReset = rst;
      pendPush  = v && expReady && !rst;
      pendSel   = sel;
      pendData  = d;
      pendPop1  = r1 && (occ1 > 0) && !rst;
      pendPop2  = r2 && (occ2 > 0) && !rst;
`ifdef DEMUX_STATS_EN
      pendDrop  = v && !expReady && !rst;
`endif
   endtask

   // Monitor: compares presented heads against the scoreboard and retires them on handshake.
   always @(negedge clock) begin
      if (!reset) begin
         checkOutput("out1_valid", 32'(out1_valid), 32'(q1.size() > 0));
         if (q1.size() > 0) begin
            checkOutput("out1_data", 32'(out1), 32'(q1[0]));
            if (out1_ready) void'(q1.pop_front());
         end else begin
            checkOutput("out1_zero", 32'(out1), 32'h0);
         end
         checkOutput("out2_valid", 32'(out2_valid), 32'(q2.size() > 0));
         if (q2.size() > 0) begin
            checkOutput("out2_data", 32'(out2), 32'(q2[0]));
            if (out2_ready) void'(q2.pop_front());
         end else begin
            checkOutput("out2_zero", 32'(out2), 32'h0);
         end
      end
   end

   initial begin
      applyStimulus(1, 0, 0, 8'h00, 0, 0);
      applyStimulus(1, 1, 0, 8'hEE, 1, 1);
      applyStimulus(0, 0, 0, 8'h00, 0, 0);
      applyStimulus(0, 0, 1, 8'h00, 0, 0);

      applyStimulus(0, 1, 0, 8'hA5, 0, 0);
      applyStimulus(0, 0, 0, 8'h00, 0, 0);
      applyStimulus(0, 0, 0, 8'h00, 1, 0);
      applyStimulus(0, 0, 0, 8'h00, 0, 0);

      applyStimulus(0, 1, 1, 8'h11, 0, 0);
      applyStimulus(0, 1, 1, 8'h22, 0, 0);
      applyStimulus(0, 1, 1, 8'h33, 0, 0);
      applyStimulus(0, 1, 0, 8'h44, 0, 0);
      applyStimulus(0, 1, 1, 8'h55, 0, 1);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 8'h00, 1, 1);

      for (int i = 1; i <= 6; i++) applyStimulus(0, 1, 0, 8'(i), i > 1, 0);
      applyStimulus(0, 0, 0, 8'h00, 1, 0);
      applyStimulus(0, 0, 0, 8'h00, 1, 0);

      applyStimulus(0, 1, 0, 8'h71, 0, 0);
      applyStimulus(0, 1, 1, 8'h72, 0, 0);
      applyStimulus(1, 1, 1, 8'h73, 1, 1);
      applyStimulus(0, 1, 1, 8'h3C, 0, 0);
      applyStimulus(0, 0, 0, 8'h00, 0, 0);
      applyStimulus(0, 0, 0, 8'h00, 0, 1);

      for (int i = 0; i < 400; i++) begin
         applyStimulus(0, 1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom),
                       1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0));
      end
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 8'h00, 1, 1);

`ifdef DEMUX_STATS_EN
      applyStimulus(1, 0, 0, 8'h00, 0, 0);
      for (int i = 0; i < 300; i++) applyStimulus(0, 1, 0, 8'($urandom), 1, 0);
      applyStimulus(0, 0, 0, 8'h00, 1, 0);
      applyStimulus(0, 0, 0, 8'h00, 1, 0);
      checkOutput("cnt1_300", 32'(cnt1), 32'd44);
      checkOutput("cnt2_idle", 32'(cnt2), 32'd0);
      applyStimulus(0, 1, 1, 8'h91, 0, 0);
      applyStimulus(0, 1, 1, 8'h92, 0, 0);
      applyStimulus(0, 1, 1, 8'h93, 0, 0);
      applyStimulus(0, 0, 0, 8'h00, 0, 0);
      checkOutput("drop_full", 32'(drop), 32'd1);
      applyStimulus(0, 0, 0, 8'h00, 0, 1);
      applyStimulus(0, 0, 0, 8'h00, 0, 1);
`endif
      applyStimulus(0, 0, 0, 8'h00, 0, 0);
      @(posedge clock);
      #2;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
